// File: rtl/a2d_round_robin_pkg.sv
// -----------------------------------------------------------------------------
// a2d_pkg
// Shared definitions for the A2D round-robin sequencer:
//   state_t  - sequencer FSM states
//   chan_t   - channel-index enum (conversion order LFT -> RGHT -> BATT)
//   RD_CMD   - command word sent during the result-read transaction
//   chan_cmd - builds the channel-select command word from a channel number
// -----------------------------------------------------------------------------
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CH,
        WAIT_CH,
        SEND_RD,
        WAIT_RD
    } state_t;

    typedef enum logic [1:0] {
        LFT,
        RGHT,
        BATT
    } chan_t;

    localparam logic [15:0] RD_CMD = 16'h0000;

    // Channel number sits in bits [13:11]; the remaining bits are zero.
    function automatic logic [15:0] chan_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_round_robin_if.sv
// -----------------------------------------------------------------------------
// a2d_round_robin_if
// SPI-master handshake between the A2D sequencer and the 16-bit SPI master.
//   wrt     - one-cycle pulse starting an SPI transaction (sequencer -> SPI)
//   cmd     - 16-bit command word                       (sequencer -> SPI)
//   done    - transaction complete, pulse or level      (SPI -> sequencer)
//   rd_data - 16-bit read data, valid when done rises   (SPI -> sequencer)
// Modports: master = sequencer side, slave = SPI-master side.
// -----------------------------------------------------------------------------
interface a2d_round_robin_if;
    import a2d_pkg::*;

    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);

endinterface

// File: rtl/a2d_round_robin.sv
// -----------------------------------------------------------------------------
// a2d_round_robin
// Converts one A2D channel per nxt request in the fixed order left load cell,
// right load cell, battery, then wraps. Each conversion is a channel-select
// SPI transaction followed by a result-read transaction; the 12-bit result is
// held in the register belonging to that channel.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   nxt       - one-cycle request to convert the next channel
//   spi       - SPI master handshake (wrt, cmd, done, rd_data)
//   lft_ld    - last left load-cell result
//   rght_ld   - last right load-cell result
//   batt      - last battery result
//   busy      - conversion in progress
//   cnv_cmplt - one-cycle pulse, result register updated on the same edge
// -----------------------------------------------------------------------------
module a2d_round_robin
    import a2d_pkg::*;
#(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    nxt,
    a2d_round_robin_if.master       spi,
    output logic [11:0]             lft_ld,
    output logic [11:0]             rght_ld,
    output logic [11:0]             batt,
    output logic                    busy,
    output logic                    cnv_cmplt
);

    state_t state;
    state_t state_nxt;
    chan_t  idx;
    logic   done_q;
    logic   done_rise;
    logic   capture;

    function automatic logic [2:0] chan_num(input chan_t c);
        case (c)
            LFT:     return LFT_CH;
            RGHT:    return RGHT_CH;
            default: return BATT_CH;
        endcase
    endfunction

    // A level-held done advances the FSM only once.
    assign done_rise = spi.done & ~done_q;
    assign capture   = (state == WAIT_RD) && done_rise;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (nxt) state_nxt = SEND_CH;
            SEND_CH: state_nxt = WAIT_CH;
            WAIT_CH: if (done_rise) state_nxt = SEND_RD;
            SEND_RD: state_nxt = WAIT_RD;
            WAIT_RD: if (done_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so wrt/cmd/busy appear in
    // the cycle right after the edge that moves the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= LFT;
            done_q    <= 1'b0;
            spi.wrt   <= 1'b0;
            spi.cmd   <= 16'h0000;
            busy      <= 1'b0;
            cnv_cmplt <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            batt      <= 12'h000;
        end else begin
            state     <= state_nxt;
            done_q    <= spi.done;
            spi.wrt   <= (state_nxt == SEND_CH) || (state_nxt == SEND_RD);
            busy      <= (state_nxt != IDLE);
            cnv_cmplt <= capture;

            if (state_nxt == SEND_CH) begin
                spi.cmd <= chan_cmd(chan_num(idx));
            end else if (state_nxt == SEND_RD) begin
                spi.cmd <= RD_CMD;
            end

            // Upper nibble of the read word carries no data and is dropped.
            if (capture) begin
                case (idx)
                    LFT:     lft_ld  <= spi.rd_data[11:0];
                    RGHT:    rght_ld <= spi.rd_data[11:0];
                    default: batt    <= spi.rd_data[11:0];
                endcase
                case (idx)
                    LFT:     idx <= RGHT;
                    RGHT:    idx <= BATT;
                    default: idx <= LFT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_a2d_round_robin.sv
module tb_a2d_round_robin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        busy;
    logic        cnv_cmplt;

    a2d_round_robin_if spi_if ();

    a2d_round_robin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .spi       (spi_if),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .busy      (busy),
        .cnv_cmplt (cnv_cmplt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: conversion order, channel numbers and held results.
    int          m_idx;
    logic [11:0] m_reg [3];
    int          ch_tab [3] = '{0, 4, 5};

    int wrt_cnt;
    int cnv_cnt;

    function automatic logic [15:0] model_cmd(input int k);
        return 16'(ch_tab[k] * 2048);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cstep();
        step();
        if (spi_if.wrt) wrt_cnt++;
        if (cnv_cmplt)  cnv_cnt++;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_lft"},  {4'h0, lft_ld},  {4'h0, m_reg[0]});
        chk({tag, "_rght"}, {4'h0, rght_ld}, {4'h0, m_reg[1]});
        chk({tag, "_batt"}, {4'h0, batt},    {4'h0, m_reg[2]});
    endtask

    // One full conversion. hold=0: 1-cycle done pulse; hold>0: done held that
    // many cycles. spam: random nxt pulses while busy.
    task automatic do_conv(input logic [15:0] rdv, input int hold, input bit spam);
        logic [15:0] exp_cmd;
        int d;
        exp_cmd = model_cmd(m_idx);
        wrt_cnt = 0;
        cnv_cnt = 0;
        chk("idle_busy", {15'h0, busy}, 16'h0);
        nxt = 1'b1;
        cstep();
        nxt = 1'b0;
        chk("wrt_ch", {15'h0, spi_if.wrt}, 16'h1);
        chk("cmd_ch", spi_if.cmd, exp_cmd);
        chk("busy_up", {15'h0, busy}, 16'h1);
        d = $urandom_range(1, 4);
        repeat (d) begin
            if (spam) nxt = 1'($urandom_range(0, 1));
            cstep();
        end
        chk("cmd_hold_ch", spi_if.cmd, exp_cmd);
        spi_if.rd_data = 16'($urandom);
        spi_if.done = 1'b1;
        cstep();
        chk("wrt_rd", {15'h0, spi_if.wrt}, 16'h1);
        chk("cmd_rd", spi_if.cmd, 16'h0000);
        if (hold > 0) begin
            repeat (hold - 1) begin
                if (spam) nxt = 1'($urandom_range(0, 1));
                cstep();
            end
        end
        spi_if.done = 1'b0;
        d = $urandom_range(1, 4);
        repeat (d) begin
            if (spam) nxt = 1'($urandom_range(0, 1));
            cstep();
        end
        chk("busy_mid", {15'h0, busy}, 16'h1);
        chk("cmd_hold_rd", spi_if.cmd, 16'h0000);
        chk_regs("pre_cap");
        spi_if.rd_data = rdv;
        spi_if.done = 1'b1;
        if (spam) nxt = 1'b1;
        cstep();
        nxt = 1'b0;
        m_reg[m_idx] = rdv[11:0];
        m_idx = (m_idx + 1) % 3;
        chk("cnv_cmplt", {15'h0, cnv_cmplt}, 16'h1);
        chk("busy_fall", {15'h0, busy}, 16'h0);
        chk_regs("post_cap");
        if (hold > 0) begin
            repeat (hold - 1) cstep();
        end
        spi_if.done = 1'b0;
        spi_if.rd_data = 16'($urandom);
        repeat (3) cstep();
        chk("cnv_pulse_end", {15'h0, cnv_cmplt}, 16'h0);
        chk("busy_stays_low", {15'h0, busy}, 16'h0);
        chk("wrt_count", 16'(wrt_cnt), 16'd2);
        chk("cnv_count", 16'(cnv_cnt), 16'd1);
        chk_regs("settled");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wrt"},  {15'h0, spi_if.wrt}, 16'h0);
        chk({tag, "_cmd"},  spi_if.cmd, 16'h0000);
        chk({tag, "_busy"}, {15'h0, busy}, 16'h0);
        chk({tag, "_cnv"},  {15'h0, cnv_cmplt}, 16'h0);
        chk({tag, "_lft"},  {4'h0, lft_ld}, 16'h0);
        chk({tag, "_rght"}, {4'h0, rght_ld}, 16'h0);
        chk({tag, "_batt"}, {4'h0, batt}, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        nxt = 1'b0;
        spi_if.done = 1'b0;
        spi_if.rd_data = 16'h0000;
        m_idx = 0;
        m_reg[0] = 12'h000;
        m_reg[1] = 12'h000;
        m_reg[2] = 12'h000;

        // Reset state
        repeat (2) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // First conversion (left)
        do_conv(16'hFABC, 0, 1'b0);
        chk("lft_fabc", {4'h0, lft_ld}, 16'h0ABC);

        // Wrap through right, battery, left
        do_conv(16'h0123, 0, 1'b0);
        do_conv(16'h0456, 0, 1'b0);
        do_conv(16'h0789, 0, 1'b0);
        chk("rght_123", {4'h0, rght_ld}, 16'h0123);
        chk("batt_456", {4'h0, batt},    16'h0456);
        chk("lft_789",  {4'h0, lft_ld},  16'h0789);

        // nxt spam while busy
        do_conv(16'h0A5A, 0, 1'b1);

        // done held high for 10 cycles
        do_conv(16'h05A5, 10, 1'b0);

        // Reset while waiting for the read result
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        step();
        spi_if.done = 1'b1;
        step();
        spi_if.done = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_idx = 0;
        m_reg[0] = 12'h000;
        m_reg[1] = 12'h000;
        m_reg[2] = 12'h000;
        chk_all_zero("mid_reset");
        step();
        do_conv(16'h0111, 0, 1'b0);

        // All-ones read data, upper nibble dropped
        do_conv(16'hFFFF, 0, 1'b0);
        chk("rght_fff", {4'h0, rght_ld}, 16'h0FFF);
        chk("lft_kept", {4'h0, lft_ld},  16'h0111);

        // Randomised conversions
        for (int i = 0; i < 24; i++) begin
            int h;
            h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0;
            do_conv(16'($urandom), h, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
